ahb_sample_streamer: RTL and testbench
======================================

AHB_SAMPLE_STREAMER -- requirements
Module: ahb_sample_streamer

Interface
REQ-001 The block SHALL have parameter POLL_LIMIT, default 255: maximum status polls per sample before a timeout is declared.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-003 The block SHALL have port n_rst, input, 1 bit: asynchronous active-low reset.
REQ-004 The block SHALL have port sample_valid, input, 1 bit: an upstream sample is offered.
REQ-005 The block SHALL have port sample_in, input, 16 bits: the upstream sample value.
REQ-006 The block SHALL have port sample_ready, output, 1 bit: the streamer accepts a sample this cycle.
REQ-007 The block SHALL have port result_valid, output, 1 bit: a one-cycle pulse marking a filtered result.
REQ-008 The block SHALL have port result_out, output, 16 bits: the filtered result, held until the next result.
REQ-009 The block SHALL have port result_err, output, 1 bit: a one-cycle pulse marking a failed sample.
REQ-010 The block SHALL drive AHB-Lite manager outputs hsel (1), haddr (4), hsize (1), htrans (2), hwrite (1) and hwdata (16).
REQ-011 The block SHALL take AHB-Lite manager inputs hrdata (16) and hresp (1) from the FIR subordinate.

Function
REQ-012 The register map SHALL be: 0x0 status (bit0 busy, bit8 error); 0x2 result; 0x4 new sample; 0x6/0x8/0xA/0xC coefficients F0..F3; 0xE new-coefficient-set.
REQ-013 The block SHALL use FSM states IDLE, WR_A, WR_D, ST_A, ST_D, RS_A, RS_D, DONE and FAIL, plus CF_A/CF_D when configured.
REQ-014 sample_ready SHALL equal (state==IDLE); a handshake is sample_valid && sample_ready, and sample_in is latched on that edge.
REQ-015 On a handshake the FSM SHALL go IDLE->WR_A; transfers are non-pipelined, with htrans=NONSEQ(2'b10) only in *_A states and IDLE(2'b00) otherwise.
REQ-016 Every transfer SHALL drive hsel=1 and hsize=1 (16-bit); WR_A drives haddr=0x4, hwrite=1; WR_D drives hwdata=latched sample.
REQ-017 ST_A SHALL read haddr=0x0; in ST_D, if hrdata[8]=1 go to FAIL, else if hrdata[0]=1 increment the poll count and return to ST_A, else go to RS_A.
REQ-018 RS_A SHALL read haddr=0x2; RS_D SHALL capture hrdata into result_out and go to DONE.
REQ-019 DONE SHALL pulse result_valid for one cycle, then go to IDLE.
REQ-020 With zero busy polls, result_valid SHALL assert exactly 7 cycles after the handshake cycle.
REQ-021 hresp=1 in any *_D state SHALL go to FAIL; FAIL SHALL pulse result_err for one cycle, then go to IDLE with result_out unchanged.
REQ-022 A poll count reaching POLL_LIMIT with busy still set SHALL go to FAIL; the poll count clears on every handshake.
REQ-023 Outside *_A and *_D states, hsel, hwrite and hwdata SHALL be 0 and haddr SHALL be 0x0.

Reset
REQ-024 n_rst low SHALL immediately force state=IDLE, htrans=IDLE, hsel=0, hwrite=0, haddr=0, hwdata=0, result_out=0, result_valid=0, result_err=0 and poll count 0, even mid-transfer.
REQ-025 sample_ready SHALL be 1 in reset, or 0 in reset when STREAMER_COEFF_INIT_EN is defined.

Configuration
REQ-026 With STREAMER_COEFF_INIT_EN defined, after reset the FSM SHALL write package constants COEFF_INIT[0..3] to 0x6..0xC and then 0x0001 to 0xE (five CF_A/CF_D pairs) before entering IDLE.
REQ-027 With STREAMER_COEFF_INIT_EN defined, hresp=1 during that load SHALL pulse result_err and restart the load from F0.
REQ-028 Without STREAMER_COEFF_INIT_EN, reset SHALL go directly to IDLE and no coefficient writes SHALL be issued.

Structure
REQ-029 Package ahb_fir_pkg SHALL hold the register address constants, HTRANS_IDLE/HTRANS_NONSEQ, the state enum typedef and COEFF_INIT.
REQ-030 The poll counter and limit compare SHALL be sub-module streamer_poll_timer (clear, count, expired), sized $clog2(POLL_LIMIT+1).

Verification
REQ-031 Test: sample 0x1234 with stub status idle and result 0x0ABC -> write 0x1234 at 0x4, result_valid 7 cycles after handshake, result_out=0x0ABC.
REQ-032 Test: status busy for 3 polls then idle -> exactly 4 status reads, result_valid at cycle 13.
REQ-033 Test: POLL_LIMIT=4 with busy forever -> 4 polls, result_err pulse, back to IDLE, sample_ready=1.
REQ-034 Test: hresp=1 on the sample write, and separately status=0x0100 -> result_err pulse, no result_valid.
REQ-035 Test: n_rst pulsed during ST_D -> htrans=0 and hsel=0 in the same cycle, outputs at reset values, next sample completes normally.
REQ-036 Test: STREAMER_COEFF_INIT_EN defined -> five writes 0x6,0x8,0xA,0xC,0xE in order, and sample_ready rises only afterwards.

Source files
------------

// File: rtl/ahb_fir_pkg.sv
// rtl/ahb_fir_pkg.sv - FIR register map, AHB-Lite constants, streamer states and preload coefficients
package ahb_fir_pkg;

    localparam logic [3:0] ADDR_STATUS = 4'h0;
    localparam logic [3:0] ADDR_RESULT = 4'h2;
    localparam logic [3:0] ADDR_SAMPLE = 4'h4;
    localparam logic [3:0] ADDR_F0     = 4'h6;
    localparam logic [3:0] ADDR_F1     = 4'h8;
    localparam logic [3:0] ADDR_F2     = 4'hA;
    localparam logic [3:0] ADDR_F3     = 4'hC;
    localparam logic [3:0] ADDR_NEWSET = 4'hE;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    localparam int STATUS_BUSY_BIT = 0;
    localparam int STATUS_ERR_BIT  = 8;

    // Value written to the new-coefficient-set register to commit F0..F3
    localparam logic [15:0] NEWSET_VALUE = 16'h0001;

    // Coefficients loaded after reset when the preload is built in; [0] is F0
    localparam logic [3:0][15:0] COEFF_INIT = {16'h0400, 16'h0300, 16'h0200, 16'h0100};

    typedef enum logic [3:0] {
        IDLE, WR_A, WR_D, ST_A, ST_D, RS_A, RS_D, DONE, FAIL
`ifdef STREAMER_COEFF_INIT_EN
        , CF_A, CF_D
`endif
    } state_e;

    // Preload step 0..3 targets F0..F3; step 4 lands on the new-set register (0x6 + 8 = 0xE)
    function automatic logic [3:0] coeff_addr(input logic [2:0] idx);
        return ADDR_F0 + {idx, 1'b0};
    endfunction

    function automatic logic [15:0] coeff_data(input logic [2:0] idx);
        return (idx < 3'd4) ? COEFF_INIT[idx[1:0]] : NEWSET_VALUE;
    endfunction

endpackage

// File: rtl/ahb_sample_streamer_if.sv
// rtl/ahb_sample_streamer_if.sv - sample stream, result and AHB-Lite manager signals of the streamer
interface ahb_sample_streamer_if;

    logic        sample_valid;
    logic [15:0] sample_in;
    logic        sample_ready;
    logic        result_valid;
    logic [15:0] result_out;
    logic        result_err;

    logic        hsel;
    logic [3:0]  haddr;
    logic        hsize;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [15:0] hwdata;
    logic [15:0] hrdata;
    logic        hresp;

    // Streamer side: consumes samples, produces results, masters the AHB-Lite bus
    modport master (
        input  sample_valid, sample_in, hrdata, hresp,
        output sample_ready, result_valid, result_out, result_err,
        output hsel, haddr, hsize, htrans, hwrite, hwdata
    );

    // Environment side: sample source, result sink and FIR subordinate
    modport slave (
        output sample_valid, sample_in, hrdata, hresp,
        input  sample_ready, result_valid, result_out, result_err,
        input  hsel, haddr, hsize, htrans, hwrite, hwdata
    );

endinterface

// File: rtl/streamer_poll_timer.sv
// rtl/streamer_poll_timer.sv - busy-poll counter that flags the poll which exhausts the budget
module streamer_poll_timer #(
    parameter int POLL_LIMIT = 255
) (
    input  logic clk,
    input  logic n_rst,
    input  logic clear_i,
    input  logic count_i,
    output logic expired_o
);

    localparam int W = $clog2(POLL_LIMIT + 1);
    localparam logic [W-1:0] LAST = W'(POLL_LIMIT - 1);

    logic [W-1:0] count_q, count_d;

    // The busy poll being counted now is number POLL_LIMIT: the budget is spent
    assign expired_o = count_i && (count_q == LAST);

    // Clear wins over count; the counter never advances past the limit
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (count_i && !expired_o) begin
            count_d = count_q + 1'b1;
        end
    end

    // Poll count register
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/ahb_sample_streamer.sv
// rtl/ahb_sample_streamer.sv - streams samples through an AHB-Lite FIR; STREAMER_COEFF_INIT_EN adds a coefficient preload after reset
module ahb_sample_streamer
    import ahb_fir_pkg::*;
#(
    parameter int POLL_LIMIT = 255
) (
    input  logic                  clk,
    input  logic                  n_rst,
    ahb_sample_streamer_if.master bus
);

`ifdef STREAMER_COEFF_INIT_EN
    localparam logic INIT_DONE_RST = 1'b0;
    logic [2:0]  cf_idx_q, cf_idx_d;
`else
    localparam logic INIT_DONE_RST = 1'b1;
`endif

    state_e      state_q, state_d;
    logic [15:0] sample_q, sample_d;
    logic [15:0] result_q, result_d;
    logic        init_done_q, init_done_d;
    logic        err_pulse_d;
    logic        handshake;

    logic        sample_ready_q, result_valid_q, result_err_q;
    logic        hsel_q, hsel_d;
    logic        hwrite_q, hwrite_d;
    logic [1:0]  htrans_q, htrans_d;
    logic [3:0]  haddr_q, haddr_d;
    logic [15:0] hwdata_q, hwdata_d;

    logic        poll_clear, poll_count, poll_expired;

    assign handshake = bus.sample_valid && sample_ready_q;

    streamer_poll_timer #(
        .POLL_LIMIT (POLL_LIMIT)
    ) u_poll_timer (
        .clk       (clk),
        .n_rst     (n_rst),
        .clear_i   (poll_clear),
        .count_i   (poll_count),
        .expired_o (poll_expired)
    );

    // Next-state logic: one non-pipelined transfer per *_A/*_D pair
    always_comb begin
        state_d     = state_q;
        sample_d    = sample_q;
        result_d    = result_q;
        init_done_d = init_done_q;
        err_pulse_d = 1'b0;
        poll_clear  = 1'b0;
        poll_count  = 1'b0;
`ifdef STREAMER_COEFF_INIT_EN
        cf_idx_d    = cf_idx_q;
`endif
        case (state_q)
            IDLE: begin
                if (handshake) begin
                    sample_d   = bus.sample_in;
                    poll_clear = 1'b1;
                    state_d    = WR_A;
                end
`ifdef STREAMER_COEFF_INIT_EN
                else if (!init_done_q) begin
                    state_d = CF_A;
                end
`endif
            end
            WR_A: state_d = WR_D;
            WR_D: state_d = bus.hresp ? FAIL : ST_A;
            ST_A: state_d = ST_D;
            ST_D: begin
                if (bus.hresp || bus.hrdata[STATUS_ERR_BIT]) begin
                    state_d = FAIL;
                end else if (bus.hrdata[STATUS_BUSY_BIT]) begin
                    poll_count = 1'b1;
                    state_d    = poll_expired ? FAIL : ST_A;
                end else begin
                    state_d = RS_A;
                end
            end
            RS_A: state_d = RS_D;
            RS_D: begin
                if (bus.hresp) begin
                    state_d = FAIL;
                end else begin
                    result_d = bus.hrdata;
                    state_d  = DONE;
                end
            end
            DONE: state_d = IDLE;
            FAIL: state_d = IDLE;
`ifdef STREAMER_COEFF_INIT_EN
            CF_A: state_d = CF_D;
            CF_D: begin
                if (bus.hresp) begin
                    // A rejected coefficient write restarts the whole set from F0
                    err_pulse_d = 1'b1;
                    cf_idx_d    = 3'd0;
                    state_d     = CF_A;
                end else if (cf_idx_q == 3'd4) begin
                    cf_idx_d    = 3'd0;
                    init_done_d = 1'b1;
                    state_d     = IDLE;
                end else begin
                    cf_idx_d = cf_idx_q + 3'd1;
                    state_d  = CF_A;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // Bus decode for the state being entered, so bus outputs come straight from flops
    always_comb begin
        htrans_d = HTRANS_IDLE;
        hsel_d   = 1'b0;
        hwrite_d = 1'b0;
        haddr_d  = ADDR_STATUS;
        hwdata_d = '0;
        case (state_d)
            WR_A: begin
                htrans_d = HTRANS_NONSEQ;
                hsel_d   = 1'b1;
                hwrite_d = 1'b1;
                haddr_d  = ADDR_SAMPLE;
            end
            WR_D: begin
                hsel_d   = 1'b1;
                hwrite_d = 1'b1;
                haddr_d  = ADDR_SAMPLE;
                hwdata_d = sample_q;
            end
            ST_A: begin
                htrans_d = HTRANS_NONSEQ;
                hsel_d   = 1'b1;
                haddr_d  = ADDR_STATUS;
            end
            ST_D: begin
                hsel_d  = 1'b1;
                haddr_d = ADDR_STATUS;
            end
            RS_A: begin
                htrans_d = HTRANS_NONSEQ;
                hsel_d   = 1'b1;
                haddr_d  = ADDR_RESULT;
            end
            RS_D: begin
                hsel_d  = 1'b1;
                haddr_d = ADDR_RESULT;
            end
`ifdef STREAMER_COEFF_INIT_EN
            CF_A: begin
                htrans_d = HTRANS_NONSEQ;
                hsel_d   = 1'b1;
                hwrite_d = 1'b1;
                haddr_d  = coeff_addr(cf_idx_d);
            end
            CF_D: begin
                hsel_d   = 1'b1;
                hwrite_d = 1'b1;
                haddr_d  = coeff_addr(cf_idx_d);
                hwdata_d = coeff_data(cf_idx_d);
            end
`endif
            default: begin
                htrans_d = HTRANS_IDLE;
            end
        endcase
    end

    // State, datapath and registered outputs
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q        <= IDLE;
            sample_q       <= '0;
            result_q       <= '0;
            init_done_q    <= INIT_DONE_RST;
            sample_ready_q <= INIT_DONE_RST;
            result_valid_q <= 1'b0;
            result_err_q   <= 1'b0;
            htrans_q       <= HTRANS_IDLE;
            hsel_q         <= 1'b0;
            hwrite_q       <= 1'b0;
            haddr_q        <= ADDR_STATUS;
            hwdata_q       <= '0;
`ifdef STREAMER_COEFF_INIT_EN
            cf_idx_q       <= 3'd0;
`endif
        end else begin
            state_q        <= state_d;
            sample_q       <= sample_d;
            result_q       <= result_d;
            init_done_q    <= init_done_d;
            sample_ready_q <= (state_d == IDLE) && init_done_d;
            result_valid_q <= (state_d == DONE);
            result_err_q   <= (state_d == FAIL) || err_pulse_d;
            htrans_q       <= htrans_d;
            hsel_q         <= hsel_d;
            hwrite_q       <= hwrite_d;
            haddr_q        <= haddr_d;
            hwdata_q       <= hwdata_d;
`ifdef STREAMER_COEFF_INIT_EN
            cf_idx_q       <= cf_idx_d;
`endif
        end
    end

    assign bus.sample_ready = sample_ready_q;
    assign bus.result_valid = result_valid_q;
    assign bus.result_out   = result_q;
    assign bus.result_err   = result_err_q;
    assign bus.hsel         = hsel_q;
    assign bus.haddr        = haddr_q;
    assign bus.hsize        = 1'b1;
    assign bus.htrans       = htrans_q;
    assign bus.hwrite       = hwrite_q;
    assign bus.hwdata       = hwdata_q;

endmodule

// File: tb/tb_ahb_sample_streamer.sv
// tb/tb_ahb_sample_streamer.sv - scoreboard bench for ahb_sample_streamer with an AHB-Lite FIR stub
module tb_ahb_sample_streamer;

`ifdef STREAMER_COEFF_INIT_EN
    localparam logic READY_RST = 1'b0;
`else
    localparam logic READY_RST = 1'b1;
`endif

    typedef struct {
        bit          is_err;
        logic [15:0] value;
        int          cyc;
    } exp_t;

    typedef struct {
        logic [3:0]  addr;
        logic [15:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic n_rst = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    exp_t sb[$];
    wr_t  wq[$];

    int          busy_cfg = 0;
    bit          busy_forever = 1'b0;
    bit          status_err = 1'b0;
    bit          wr_err = 1'b0;
    logic [15:0] result_val = 16'h0000;
    logic [15:0] last_res = 16'h0000;

    int          status_reads = 0;
    int          busy_left = 0;
    bit          dphase = 1'b0;
    logic [3:0]  d_addr = 4'h0;
    bit          d_write = 1'b0;

    ahb_sample_streamer_if bus_if ();

    ahb_sample_streamer #(
        .POLL_LIMIT (4)
    ) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // FIR subordinate: answers each address phase during the following data phase
    always @(negedge clk) begin
        wr_t w;
        if (!n_rst) begin
            dphase = 1'b0;
        end else begin
            if (dphase && d_write) begin
                check_eq("wr_expected", {31'd0, wq.size() != 0}, 32'd1);
                if (wq.size() != 0) begin
                    w = wq.pop_front();
                    check_eq("wr_addr", {28'd0, d_addr}, {28'd0, w.addr});
                    check_eq("wr_data", {16'd0, bus_if.hwdata}, {16'd0, w.data});
                end
            end
            dphase = bus_if.hsel && (bus_if.htrans == 2'b10);
            if (dphase) begin
                d_addr = bus_if.haddr;
                d_write = bus_if.hwrite;
                bus_if.hresp = 1'b0;
                bus_if.hrdata = 16'h0000;
                if (bus_if.hwrite) begin
                    if (bus_if.haddr == 4'h4) begin
                        busy_left = busy_cfg;
                        bus_if.hresp = wr_err;
                    end
                end else if (bus_if.haddr == 4'h0) begin
                    status_reads++;
                    if (status_err) begin
                        bus_if.hrdata = 16'h0100;
                    end else if (busy_forever || busy_left > 0) begin
                        bus_if.hrdata = 16'h0001;
                        if (busy_left > 0) busy_left--;
                    end
                end else if (bus_if.haddr == 4'h2) begin
                    bus_if.hrdata = result_val;
                end
            end
        end
    end

    // Result monitor: every result or error pulse must match the oldest expectation
    always @(negedge clk) begin
        exp_t e;
        if (n_rst && (bus_if.result_valid || bus_if.result_err)) begin
            check_eq("sb_expected", {31'd0, sb.size() != 0}, 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check_eq("result_err", {31'd0, bus_if.result_err}, {31'd0, e.is_err});
                check_eq("result_valid", {31'd0, bus_if.result_valid}, {31'd0, !e.is_err});
                check_eq("result_out", {16'd0, bus_if.result_out}, {16'd0, e.value});
                check_eq("result_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        @(negedge clk);
        while (!bus_if.sample_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_eq("ready_wait", {31'd0, bus_if.sample_ready}, 32'd1);
    endtask

    // Offer one sample; lat is the expected number of cycles from handshake to the pulse
    task automatic send(input logic [15:0] s, input bit exp_err, input logic [15:0] exp_val, input int lat);
        int n = 0;
        wait_ready();
        sb.push_back('{exp_err, exp_val, cyc + lat});
        wq.push_back('{4'h4, s});
        bus_if.sample_valid = 1'b1;
        bus_if.sample_in = s;
        @(negedge clk);
        bus_if.sample_valid = 1'b0;
        bus_if.sample_in = 16'h0000;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_eq("sb_drain", sb.size(), 32'd0);
        @(negedge clk);
        if (!exp_err) last_res = exp_val;
    endtask

    task automatic expect_init();
`ifdef STREAMER_COEFF_INIT_EN
        for (int i = 0; i < 4; i++) begin
            wq.push_back('{4'h6 + 4'(2 * i), ahb_fir_pkg::COEFF_INIT[i]});
        end
        wq.push_back('{4'hE, 16'h0001});
`endif
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_htrans"}, {30'd0, bus_if.htrans}, 32'd0);
        check_eq({tag, "_hsel"}, {31'd0, bus_if.hsel}, 32'd0);
        check_eq({tag, "_hwrite"}, {31'd0, bus_if.hwrite}, 32'd0);
        check_eq({tag, "_haddr"}, {28'd0, bus_if.haddr}, 32'd0);
        check_eq({tag, "_hwdata"}, {16'd0, bus_if.hwdata}, 32'd0);
        check_eq({tag, "_result_out"}, {16'd0, bus_if.result_out}, 32'd0);
        check_eq({tag, "_result_valid"}, {31'd0, bus_if.result_valid}, 32'd0);
        check_eq({tag, "_result_err"}, {31'd0, bus_if.result_err}, 32'd0);
        check_eq({tag, "_ready"}, {31'd0, bus_if.sample_ready}, {31'd0, READY_RST});
    endtask

    initial begin
        int base;
        int b;
        int n;
        bit found;
        logic [15:0] r;
        logic [15:0] s;

        bus_if.sample_valid = 1'b0;
        bus_if.sample_in = 16'h0000;
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        expect_init();
        n_rst = 1'b1;

`ifdef STREAMER_COEFF_INIT_EN
        wait_ready();
        check_eq("init_writes_done", wq.size(), 32'd0);
`endif

        // Plain sample, status idle on the first poll
        result_val = 16'h0ABC;
        base = status_reads;
        send(16'h1234, 1'b0, 16'h0ABC, 7);
        check_eq("t1_status_reads", status_reads - base, 32'd1);
        check_eq("t1_result_hold", {16'd0, bus_if.result_out}, 32'h0ABC);
        check_eq("t1_idle_hsel", {31'd0, bus_if.hsel}, 32'd0);

        // Busy for three polls, idle on the fourth
        busy_cfg = 3;
        result_val = 16'h5555;
        base = status_reads;
        send(16'hBEEF, 1'b0, 16'h5555, 13);
        check_eq("t2_status_reads", status_reads - base, 32'd4);
        busy_cfg = 0;

        // Busy forever: poll budget of 4 runs out
        busy_forever = 1'b1;
        base = status_reads;
        send(16'h0F0F, 1'b1, 16'h5555, 11);
        check_eq("t3_status_reads", status_reads - base, 32'd4);
        check_eq("t3_ready", {31'd0, bus_if.sample_ready}, 32'd1);
        busy_forever = 1'b0;

        // Error response on the sample write
        wr_err = 1'b1;
        base = status_reads;
        send(16'h1111, 1'b1, 16'h5555, 3);
        check_eq("t4_status_reads", status_reads - base, 32'd0);
        wr_err = 1'b0;

        // Status reports the FIR error bit
        status_err = 1'b1;
        send(16'h2222, 1'b1, 16'h5555, 5);
        status_err = 1'b0;
        check_eq("t5_ready", {31'd0, bus_if.sample_ready}, 32'd1);

        // Random samples with a few busy polls
        for (int i = 0; i < 4; i++) begin
            b = $urandom_range(0, 3);
            r = 16'($urandom_range(1, 16'hFFFF));
            s = 16'($urandom);
            busy_cfg = b;
            result_val = r;
            send(s, 1'b0, r, 7 + 2 * b);
        end
        busy_cfg = 0;

        // Reset asserted while the status read is in its data phase
        wait_ready();
        wq.push_back('{4'h4, 16'h4444});
        bus_if.sample_valid = 1'b1;
        bus_if.sample_in = 16'h4444;
        @(negedge clk);
        bus_if.sample_valid = 1'b0;
        found = 1'b0;
        n = 0;
        while (!found && n < 20) begin
            if (bus_if.hsel && bus_if.htrans == 2'b00 && !bus_if.hwrite && bus_if.haddr == 4'h0) begin
                found = 1'b1;
            end else begin
                @(negedge clk);
                n++;
            end
        end
        check_eq("t6_reached_st_d", {31'd0, found}, 32'd1);
        check_eq("t6_result_before", {16'd0, bus_if.result_out}, {16'd0, last_res});
        #2;
        n_rst = 1'b0;
        #1;
        check_reset_outputs("mid_rst");
        sb.delete();
        @(negedge clk);
        expect_init();
        n_rst = 1'b1;
        result_val = 16'h7777;
        send(16'h3333, 1'b0, 16'h7777, 7);
        check_eq("t6_result_after", {16'd0, bus_if.result_out}, 32'h7777);
        check_eq("t6_writes_done", wq.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Absolute bound so the run always ends
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete (cycle %0d)", cyc);
        $fatal(1, "global timeout");
    end

endmodule
